// File: rtl/fifo_pkg.sv
// Shared constants and types for the 16x8 synchronous FIFO and its drain-side reader.
package fifo_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;

    typedef logic [DATA_W-1:0] data_t;

    // Pointer width for a circular buffer of the given depth (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready byte stream presented by the FIFO reader to its consumer.
interface fifo_stream_reader_if #(
    parameter int DATA_W = fifo_pkg::DATA_W
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_stream_reader_buf.sv
// Small circular buffer absorbing the FIFO read latency; head entry is always visible.
module reader_buf
    import fifo_pkg::*;
#(
    parameter  int DATA_W = fifo_pkg::DATA_W,
    parameter  int DEPTH  = 2,
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [OCC_W-1:0]  occ,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
        end else begin
            if (push) tail_ptr <= next_ptr(tail_ptr);
            if (pop)  head_ptr <= next_ptr(head_ptr);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Storage carries no reset; only occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= din;
    end

    assign head = mem[head_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drain-side reader for the 16x8 FIFO: issues reads, tracks write-priority drops, streams bytes out.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W    = fifo_pkg::DATA_W,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 fifo_rd,
    input  logic [DATA_W-1:0]    fifo_dout,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    input  logic                 fifo_wr_mon,
    fifo_stream_reader_if.master strm,
    output logic [CNT_W-1:0]     rd_count,
    output logic                 idle
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(BUF_DEPTH);

    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    level;
    logic [DATA_W-1:0] head;
    logic              pending;
    logic              pop;
    logic              rd_accept;

    reader_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (pending),
        .din  (fifo_dout),
        .pop  (pop),
        .occ  (occ),
        .head (head)
    );

    assign strm.m_valid = (occ != '0);
    assign strm.m_data  = head;

    // Occupancy seen after this cycle's pop, counting the byte still in flight from the FIFO.
    always_comb begin
        pop       = strm.m_valid & strm.m_ready;
        level     = {1'b0, occ} + (OCC_W + 1)'(pending) - (OCC_W + 1)'(pop);
        fifo_rd   = ~rst & en & ~fifo_empty & (level < DEPTH_L);
        rd_accept = fifo_rd & ~fifo_empty & ~(fifo_wr_mon & ~fifo_full);
        idle      = ~pending & (occ == '0) & (rst | fifo_empty | ~en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= 1'b0;
            rd_count <= '0;
        end else begin
            pending <= rd_accept;
            if (rd_accept) rd_count <= rd_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized bench for fifo_stream_reader with a behavioural FIFO and count-based reference.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 12;
    localparam int N_LONG    = 5000;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             fifo_rd;
    data_t            fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_wr_mon;
    data_t            wdata;
    logic [CNT_W-1:0] rd_count;
    logic             idle;

    fifo_stream_reader_if #(.DATA_W(DATA_W)) strm ();

    fifo_stream_reader #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fifo_rd     (fifo_rd),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_wr_mon (fifo_wr_mon),
        .strm        (strm.master),
        .rd_count    (rd_count),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    int    passed = 0;
    int    total  = 0;
    data_t fifo_q[$];
    data_t exp_q[$];
    int    acc_total;
    int    pop_total;
    bit    acc_last;
    bit    last_rd;
    bit    last_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic upd_flags();
        fifo_empty = (fifo_q.size() == 0);
        fifo_full  = (fifo_q.size() == FIFO_DEPTH);
    endtask

    task automatic preload(input data_t d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        upd_flags();
    endtask

    // One clock: check outputs against the count model, then advance model and FIFO.
    task automatic tick();
        int    inflight;
        bit    ev, pm, er, ea, ei, wacc, rd_seen;
        data_t ed;
        #1;
        inflight = acc_total - pop_total;
        ev   = (inflight - int'(acc_last)) > 0;
        pm   = ev & strm.m_ready;
        er   = en & !fifo_empty & ((inflight - int'(pm)) < BUF_DEPTH);
        wacc = fifo_wr_mon & !fifo_full;
        ea   = er & !wacc;
        ei   = (inflight == 0) & (fifo_empty | !en);
        check("m_valid", strm.m_valid, ev);
        check("fifo_rd", fifo_rd, er);
        check("idle", idle, ei);
        check("rd_count", rd_count, acc_total % (1 << CNT_W));
        check("occ_bound", dut.occ <= BUF_DEPTH, 1);
        if (pm) begin
            ed = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("m_data", strm.m_data, ed);
        end
        rd_seen  = fifo_rd;
        last_rd  = fifo_rd;
        last_pop = strm.m_valid & strm.m_ready;
        @(posedge clk);
        #1;
        acc_total += int'(ea);
        acc_last   = ea;
        pop_total += int'(pm);
        if (wacc) begin
            fifo_q.push_back(wdata);
            exp_q.push_back(wdata);
        end else if (rd_seen && !fifo_empty) begin
            fifo_dout = fifo_q.pop_front();
        end
        upd_flags();
    endtask

    task automatic run_mask(input int n, output logic [15:0] rdm, output logic [15:0] popm);
        rdm  = '0;
        popm = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            rdm[i]  = last_rd;
            popm[i] = last_pop;
        end
    endtask

    // Reset is checked while asserted; the FIFO model is flushed alongside it.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_m_valid", strm.m_valid, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_idle", idle, 1);
        @(posedge clk);
        #1;
        fifo_q.delete();
        exp_q.delete();
        acc_total   = 0;
        pop_total   = 0;
        acc_last    = 0;
        fifo_dout   = '0;
        fifo_wr_mon = 1'b0;
        upd_flags();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] rdm, popm;
        int written, popped;
        rst = 1'b1; en = 1'b0; strm.m_ready = 1'b0; fifo_wr_mon = 1'b0;
        wdata = '0; fifo_dout = '0;
        upd_flags();
        do_reset();

        // Full-throughput drain of three bytes.
        preload(8'h11); preload(8'h22); preload(8'h33);
        en = 1'b1; strm.m_ready = 1'b1;
        run_mask(8, rdm, popm);
        check("t1_rd_mask", rdm, 16'h0007);
        check("t1_pop_mask", popm, 16'h001C);
        check("t1_rd_count", rd_count, 3);
        check("t1_idle", idle, 1);

        // Backpressure: only BUF_DEPTH reads, head held stable.
        do_reset();
        preload(8'h11); preload(8'h22); preload(8'h33);
        en = 1'b1; strm.m_ready = 1'b0;
        run_mask(6, rdm, popm);
        check("t2_rd_mask", rdm, 16'h0003);
        check("t2_rd_count", rd_count, 2);
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_valid", strm.m_valid, 1);
            check("t2_hold_data", strm.m_data, 8'h11);
            tick();
        end
        strm.m_ready = 1'b1;
        run_mask(8, rdm, popm);
        check("t2_resume_pops", popm, 16'h0007);
        check("t2_rd_count_end", rd_count, 3);

        // Write priority drops the second read.
        do_reset();
        preload(8'h11); preload(8'h22); preload(8'h33);
        en = 1'b1; strm.m_ready = 1'b1;
        tick();
        fifo_wr_mon = 1'b1; wdata = 8'h44;
        tick();
        fifo_wr_mon = 1'b0;
        check("t3_rd_during_wr", last_rd, 1);
        check("t3_count_after_drop", rd_count, 1);
        tick();
        check("t3_no_capture", strm.m_valid, 0);
        run_mask(10, rdm, popm);
        check("t3_pop_count", $countones(popm), 3);
        check("t3_rd_count", rd_count, 4);

        // Enable gap mid-stream.
        do_reset();
        for (int i = 1; i <= 6; i++) preload(data_t'(i));
        en = 1'b1; strm.m_ready = 1'b1;
        tick(); tick();
        en = 1'b0;
        run_mask(3, rdm, popm);
        check("t4_rd_off", rdm, 16'h0000);
        check("t4_inflight_pops", popm, 16'h0003);
        en = 1'b1;
        run_mask(12, rdm, popm);
        check("t4_resume_pops", $countones(popm), 4);
        check("t4_rd_count", rd_count, 6);

        // Reset with bytes buffered and one in flight.
        do_reset();
        preload(8'h11); preload(8'h22); preload(8'h33);
        en = 1'b1; strm.m_ready = 1'b0;
        tick(); tick();
        check("t5_pending", dut.pending, 1);
        check("t5_occ", dut.occ, 1);
        do_reset();
        tick();
        check("t5_idle_after", idle, 1);

        // Long randomized run with counter wrap.
        do_reset();
        written = 0;
        popped  = 0;
        for (int cyc = 0; cyc < 60000 && !(written == N_LONG && popped == N_LONG); cyc++) begin
            strm.m_ready = ($urandom_range(0, 3) != 0);
            en           = ($urandom_range(0, 15) != 0);
            wdata        = data_t'($urandom);
            if (written < N_LONG && !fifo_full && $urandom_range(0, 1) == 1)
                fifo_wr_mon = 1'b1;
            else if (written < N_LONG && fifo_full && $urandom_range(0, 7) == 0)
                fifo_wr_mon = 1'b1;
            else
                fifo_wr_mon = 1'b0;
            if (fifo_wr_mon && !fifo_full) written++;
            tick();
            if (last_pop) popped++;
        end
        fifo_wr_mon = 1'b0;
        en = 1'b1;
        check("t6_popped", popped, N_LONG);
        check("t6_rd_count_wrap", rd_count, N_LONG % (1 << CNT_W));
        check("t6_scoreboard_empty", exp_q.size(), 0);
        tick();
        check("t6_idle", idle, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
